// File: rtl/fram_arb_pkg.sv
// Shared definitions for the FRAM command/data arbiter: FSM states, default
// timing limits and fixed requester slots.
package fram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ACK,
        BUSY
    } arb_state_t;

    localparam int unsigned DEF_TMO_CYC = 50000;
    localparam int unsigned DEF_ACK_CYC = 8;
    localparam int unsigned IDX_W       = 2;

    localparam logic [IDX_W-1:0] AREA2 = 2'd0;
    localparam logic [IDX_W-1:0] AREA3 = 2'd1;
    localparam logic [IDX_W-1:0] SPARE = 2'd2;

    // Successor of idx in a ring of n requesters.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input int unsigned n);
        if (32'(idx) + 32'd1 >= n)
            return '0;
        else
            return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/fram_rr_pick.sv
// Combinational round-robin pick: first active request at or after ptr,
// wrapping around the requester ring.
module fram_rr_pick
    import fram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        j      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!valid && req[j]) begin
                valid     = 1'b1;
                onehot[j] = 1'b1;
                idx       = j;
            end
        end
    end

endmodule

// File: rtl/fram_arbiter.sv
// Arbitrates the FRAM controller interface among NUM_REQ scan engines with a
// registered one-hot grant, round-robin fairness and a per-grant watchdog.
module fram_arbiter
    import fram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned TMO_CYC = DEF_TMO_CYC,
    parameter int unsigned ACK_CYC = DEF_ACK_CYC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     im_req,
    output logic [NUM_REQ-1:0]     om_gnt,
    input  logic [NUM_REQ-1:0]     im_rden,
    input  logic [NUM_REQ-1:0]     im_wren,
    input  logic [16*NUM_REQ-1:0]  im_addr,
    input  logic [16*NUM_REQ-1:0]  im_len,
    input  logic [NUM_REQ-1:0]     im_wr_dv,
    input  logic [8*NUM_REQ-1:0]   im_wdata,
    output logic [NUM_REQ-1:0]     om_rd_dv,
    output logic [7:0]             om_rdata,
    output logic                   o_fram_rden,
    output logic                   o_fram_wren,
    output logic                   o_fram_wr_dv,
    output logic [15:0]            om_fram_addr,
    output logic [15:0]            om_fram_wr_len,
    output logic [7:0]             o_fram_wdata,
    input  logic                   i_fram_rdy,
    input  logic                   i_fram_rd_dv,
    input  logic [7:0]             im_fram_rdata,
    output logic                   o_error,
    output logic [1:0]             om_err_src
);

    arb_state_t        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  winner;
    logic [15:0]       wdog;
    logic [15:0]       ack_cnt;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               rden_any;
    logic               wren_any;
    logic               cmd;
    logic               req_held;
    logic               tmo;
    logic               ack_tmo;
    logic [IDX_W-1:0]   rel_ptr;

    fram_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (im_req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // AND-OR mux keyed by the registered grant: zero grant gives all-zero outputs.
    always_comb begin
        rden_any       = 1'b0;
        wren_any       = 1'b0;
        o_fram_wr_dv   = 1'b0;
        om_fram_addr   = '0;
        om_fram_wr_len = '0;
        o_fram_wdata   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rden_any       = rden_any     | (im_rden[k]  & om_gnt[k]);
            wren_any       = wren_any     | (im_wren[k]  & om_gnt[k]);
            o_fram_wr_dv   = o_fram_wr_dv | (im_wr_dv[k] & om_gnt[k]);
            om_fram_addr   = om_fram_addr   | (im_addr[16*k +: 16]  & {16{om_gnt[k]}});
            om_fram_wr_len = om_fram_wr_len | (im_len[16*k +: 16]   & {16{om_gnt[k]}});
            o_fram_wdata   = o_fram_wdata   | (im_wdata[8*k +: 8]   & {8{om_gnt[k]}});
        end
    end

    assign o_fram_rden = rden_any;
    assign o_fram_wren = wren_any & ~rden_any;
    assign om_rd_dv    = i_fram_rd_dv ? om_gnt : '0;
    assign om_rdata    = im_fram_rdata;

    assign cmd      = rden_any | wren_any;
    assign req_held = |(im_req & om_gnt);
    assign tmo      = (wdog == 16'(TMO_CYC - 1));
    assign ack_tmo  = (ack_cnt == 16'(ACK_CYC - 1));
    assign rel_ptr  = next_idx(winner, NUM_REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            om_gnt     <= '0;
            ptr        <= '0;
            winner     <= '0;
            wdog       <= '0;
            ack_cnt    <= '0;
            o_error    <= 1'b0;
            om_err_src <= '0;
        end else begin
            o_error <= 1'b0;
            if (state != IDLE)
                wdog <= wdog + 16'd1;

            case (state)
                IDLE: begin
                    if (pick_valid && i_fram_rdy) begin
                        om_gnt <= pick_onehot;
                        winner <= pick_idx;
                        wdog   <= '0;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (cmd) begin
                        ack_cnt <= '0;
                        state   <= ACK;
                    end else if (!req_held) begin
                        om_gnt <= '0;
                        ptr    <= rel_ptr;
                        state  <= IDLE;
                    end
                end
                ACK: begin
                    if (!i_fram_rdy) begin
                        state <= BUSY;
                    end else if (ack_tmo) begin
                        o_error    <= 1'b1;
                        om_err_src <= winner;
                        om_gnt     <= '0;
                        ptr        <= rel_ptr;
                        state      <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 16'd1;
                    end
                end
                BUSY: begin
                    if (i_fram_rdy) begin
                        om_gnt <= '0;
                        ptr    <= rel_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Watchdog overrides whatever the state decided this cycle.
            if (state != IDLE && tmo) begin
                o_error    <= 1'b1;
                om_err_src <= winner;
                om_gnt     <= '0;
                ptr        <= rel_ptr;
                state      <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fram_arbiter.sv
// Directed self-checking bench for fram_arbiter (TMO_CYC=100, ACK_CYC=8).
module tb_fram_arbiter;

    localparam int unsigned N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    im_req, om_gnt, im_rden, im_wren, im_wr_dv, om_rd_dv;
    logic [16*N-1:0] im_addr, im_len;
    logic [8*N-1:0]  im_wdata;
    logic [7:0]      om_rdata, o_fram_wdata, im_fram_rdata;
    logic            o_fram_rden, o_fram_wren, o_fram_wr_dv;
    logic [15:0]     om_fram_addr, om_fram_wr_len;
    logic            i_fram_rdy, i_fram_rd_dv, o_error;
    logic [1:0]      om_err_src;

    int checks = 0;
    int errors = 0;

    fram_arbiter #(.NUM_REQ(N), .TMO_CYC(100), .ACK_CYC(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .im_req         (im_req),
        .om_gnt         (om_gnt),
        .im_rden        (im_rden),
        .im_wren        (im_wren),
        .im_addr        (im_addr),
        .im_len         (im_len),
        .im_wr_dv       (im_wr_dv),
        .im_wdata       (im_wdata),
        .om_rd_dv       (om_rd_dv),
        .om_rdata       (om_rdata),
        .o_fram_rden    (o_fram_rden),
        .o_fram_wren    (o_fram_wren),
        .o_fram_wr_dv   (o_fram_wr_dv),
        .om_fram_addr   (om_fram_addr),
        .om_fram_wr_len (om_fram_wr_len),
        .o_fram_wdata   (o_fram_wdata),
        .i_fram_rdy     (i_fram_rdy),
        .i_fram_rd_dv   (i_fram_rd_dv),
        .im_fram_rdata  (im_fram_rdata),
        .o_error        (o_error),
        .om_err_src     (om_err_src)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [N-1:0] order [4];

    initial begin
        rst = 1'b1; im_req = '0; im_rden = '0; im_wren = '0; im_wr_dv = '0;
        im_addr = '0; im_len = '0; im_wdata = '0; i_fram_rdy = 1'b1;
        i_fram_rd_dv = 1'b0; im_fram_rdata = '0;
        repeat (3) tick();
        chk("rst_gnt", 32'(om_gnt), 0);
        chk("rst_rden", 32'(o_fram_rden), 0);
        chk("rst_wren", 32'(o_fram_wren), 0);
        chk("rst_wrdv", 32'(o_fram_wr_dv), 0);
        chk("rst_addr", 32'(om_fram_addr), 0);
        chk("rst_len", 32'(om_fram_wr_len), 0);
        chk("rst_rddv", 32'(om_rd_dv), 0);
        chk("rst_err", 32'(o_error), 0);
        chk("rst_src", 32'(om_err_src), 0);

        // Single write from requester 0, 4 bytes
        rst = 1'b0; im_req = 3'b001;
        #1 chk("t1_gnt_pre", 32'(om_gnt), 0);
        tick();
        chk("t1_gnt", 32'(om_gnt), 3'b001);
        im_addr[15:0] = 16'h1234; im_len[15:0] = 16'd4; im_wren[0] = 1'b1;
        #1;
        chk("t1_wren", 32'(o_fram_wren), 1);
        chk("t1_rden", 32'(o_fram_rden), 0);
        chk("t1_addr", 32'(om_fram_addr), 32'h1234);
        chk("t1_len", 32'(om_fram_wr_len), 4);
        tick();
        im_wren[0] = 1'b0;
        tick();
        i_fram_rdy = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            im_wr_dv[0] = 1'b1; im_wdata[7:0] = 8'hA0 + 8'(i);
            #1;
            chk("t1_wrdv", 32'(o_fram_wr_dv), 1);
            chk("t1_wdata", 32'(o_fram_wdata), 32'hA0 + i);
            tick();
        end
        im_wr_dv[0] = 1'b0;
        repeat (6) tick();
        chk("t1_gnt_busy", 32'(om_gnt), 3'b001);
        chk("t1_err_busy", 32'(o_error), 0);
        i_fram_rdy = 1'b1; im_req = '0;
        tick();
        chk("t1_gnt_rel", 32'(om_gnt), 0);
        chk("t1_err_rel", 32'(o_error), 0);
        chk("t1_addr_rel", 32'(om_fram_addr), 0);

        // All three requesting from reset: 0,1,2,0
        rst = 1'b1; im_req = 3'b111;
        tick(); tick();
        chk("t2_gnt_rst", 32'(om_gnt), 0);
        rst = 1'b0;
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_gnt_order", 32'(om_gnt), 32'(order[i]));
            im_req = 3'b111 & ~order[i];
            tick();
            chk("t2_gnt_gap", 32'(om_gnt), 0);
            im_req = 3'b111;
        end
        im_req = '0;
        tick();
        chk("t2_idle", 32'(om_gnt), 0);

        // Read by requester 1 (ptr now 1); rden+wren -> read only
        im_req = 3'b010;
        tick();
        chk("t3_gnt", 32'(om_gnt), 3'b010);
        im_addr[31:16] = 16'h0042; im_rden[1] = 1'b1; im_wren[1] = 1'b1;
        #1;
        chk("t3_rden", 32'(o_fram_rden), 1);
        chk("t3_wren_drop", 32'(o_fram_wren), 0);
        chk("t3_addr", 32'(om_fram_addr), 32'h42);
        tick();
        im_rden = '0; im_wren = '0; i_fram_rdy = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            i_fram_rd_dv = 1'b1; im_fram_rdata = 8'h50 + 8'(i);
            #1;
            chk("t3_rddv", 32'(om_rd_dv), 3'b010);
            chk("t3_rdata", 32'(om_rdata), 32'h50 + i);
            tick();
            i_fram_rd_dv = 1'b0;
            #1 chk("t3_rddv_low", 32'(om_rd_dv), 0);
            tick();
        end
        i_fram_rdy = 1'b1; im_req = '0;
        tick();
        chk("t3_gnt_rel", 32'(om_gnt), 0);
        i_fram_rd_dv = 1'b1;
        #1 chk("t3_rddv_nognt", 32'(om_rd_dv), 0);
        i_fram_rd_dv = 1'b0;

        // Watchdog: requester 2 (ptr now 2), rdy held low
        im_req = 3'b100;
        tick();
        chk("t4_gnt", 32'(om_gnt), 3'b100);
        im_wren[2] = 1'b1;
        tick();
        im_wren = '0; i_fram_rdy = 1'b0;
        tick();
        repeat (97) tick();
        chk("t4_err_pre", 32'(o_error), 0);
        chk("t4_gnt_pre", 32'(om_gnt), 3'b100);
        tick();
        chk("t4_err", 32'(o_error), 1);
        chk("t4_src", 32'(om_err_src), 2);
        chk("t4_gnt_rel", 32'(om_gnt), 0);
        tick();
        chk("t4_err_pulse", 32'(o_error), 0);
        chk("t4_src_sticky", 32'(om_err_src), 2);
        chk("t4_nognt_rdy0", 32'(om_gnt), 0);

        // Ack timeout on requester 0 (ptr wrapped to 0); foreign wren ignored
        im_req = 3'b001; i_fram_rdy = 1'b1;
        tick();
        chk("t5_gnt", 32'(om_gnt), 3'b001);
        im_wren[2] = 1'b1;
        #1 chk("t5_foreign_wren", 32'(o_fram_wren), 0);
        tick();
        chk("t5_gnt_hold", 32'(om_gnt), 3'b001);
        im_wren[2] = 1'b0; im_wren[0] = 1'b1;
        #1 chk("t5_wren", 32'(o_fram_wren), 1);
        tick();
        im_wren[0] = 1'b0;
        repeat (7) tick();
        chk("t5_err_pre", 32'(o_error), 0);
        chk("t5_gnt_pre", 32'(om_gnt), 3'b001);
        tick();
        chk("t5_err", 32'(o_error), 1);
        chk("t5_src", 32'(om_err_src), 0);
        chk("t5_gnt_rel", 32'(om_gnt), 0);
        im_req = '0;
        tick();
        chk("t5_err_pulse", 32'(o_error), 0);

        // Reset while BUSY with rdy low
        im_req = 3'b010;
        tick();
        chk("t6_gnt", 32'(om_gnt), 3'b010);
        im_rden[1] = 1'b1;
        tick();
        im_rden = '0; i_fram_rdy = 1'b0;
        tick();
        rst = 1'b1; im_rden[1] = 1'b1;
        tick();
        chk("t6_gnt_rst", 32'(om_gnt), 0);
        chk("t6_rden_rst", 32'(o_fram_rden), 0);
        chk("t6_addr_rst", 32'(om_fram_addr), 0);
        chk("t6_err_rst", 32'(o_error), 0);
        rst = 1'b0; im_rden = '0;
        repeat (3) tick();
        chk("t6_wait_rdy", 32'(om_gnt), 0);
        i_fram_rdy = 1'b1;
        tick();
        chk("t6_gnt_after", 32'(om_gnt), 3'b010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
